// File: rtl/pipe_pkg.sv
// Shared constants for the pipe_reg_array register pipeline.
package pipe_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_CHANNELS = 2;
  localparam int DEFAULT_DEPTH    = 2;

  // Legal range of register stages.
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  // True when a stage count lies inside the supported range.
  function automatic bit depth_legal(input int depth);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register: a valid bit and a data word with its ready equation.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DW = DEFAULT_WIDTH * DEFAULT_CHANNELS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          down_ready,
  output logic          ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_r;
  logic [DW-1:0] data_r;

  // A stage can take a new word when it is empty or its contents move on.
  assign ready = ~valid_r | down_ready;
  assign valid = valid_r;
  assign data  = data_r;

  // Stage register: flush drops the entry but keeps the data word untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
      data_r  <= data_r;
    end else if (ready) begin
      valid_r <= up_valid;
      data_r  <= up_data;
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

endmodule

// File: rtl/pipe_reg_array.sv
// Multi-lane valid/ready register pipeline of DEPTH stages with flush.
module pipe_reg_array
  import pipe_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int DEPTH    = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*WIDTH-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int OW = $clog2(DEPTH + 1);

  generate
    if (!depth_legal(DEPTH) || (WIDTH < 1) || (CHANNELS < 1)) begin : g_bad_params
      $error("pipe_reg_array: DEPTH must be 1..16, WIDTH and CHANNELS at least 1");
    end
  endgenerate

  // valid_s/data_s index 0 is the upstream port, index i+1 is stage i.
  logic [DEPTH:0]    valid_s;
  logic [DW-1:0]     data_s [DEPTH+1];
  logic [DEPTH-1:0]  down_ready_s;
  logic [DEPTH-1:0]  stage_ready_s;
  logic [OW-1:0]     occ_next_s;
  logic [OW-1:0]     occupancy_r;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;

  // Downstream ready is computed as a look-ahead over the valid bits instead of
  // rippling through each stage's ready output: stage i may advance unless every
  // stage after it is full and the consumer is stalled.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == DEPTH - 1) begin : g_last
        assign down_ready_s[i] = out_ready;
      end else begin : g_mid
        assign down_ready_s[i] = out_ready | ~(&valid_s[DEPTH:i+2]);
      end

      pipe_stage #(.DW(DW)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (valid_s[i]),
        .up_data    (data_s[i]),
        .down_ready (down_ready_s[i]),
        .ready      (stage_ready_s[i]),
        .valid      (valid_s[i+1]),
        .data       (data_s[i+1])
      );
    end
  endgenerate

  assign in_ready  = stage_ready_s[0] & ~flush;
  assign out_valid = valid_s[DEPTH];
  assign out_data  = data_s[DEPTH];
  assign occupancy = occupancy_r;

  // Population count of the valid bits each stage will hold after this edge.
  always_comb begin
    occ_next_s = '0;
    if (flush) begin
      occ_next_s = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (stage_ready_s[i]) begin
          occ_next_s = occ_next_s + OW'(valid_s[i]);
        end else begin
          occ_next_s = occ_next_s + OW'(valid_s[i+1]);
        end
      end
    end
  end

  // Occupancy register tracks the stage valid bits edge for edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy_r <= '0;
    end else begin
      occupancy_r <= occ_next_s;
    end
  end

endmodule

// File: tb/tb_pipe_reg_array.sv
// Self-checking bench for pipe_reg_array (WIDTH=8, CHANNELS=2, DEPTH=3).
module tb_pipe_reg_array;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 3;
  localparam int DW       = WIDTH * CHANNELS;
  localparam int OW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_reg_array #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Reference model: queue of entries, oldest first, each with its stage position.
  typedef struct {
    logic [DW-1:0] d;
    int            pos;
  } ent_t;
  ent_t q[$];

  function automatic logic m_in_ready();
    return !flush && !((q.size() == DEPTH) && !out_ready);
  endfunction

  function automatic logic m_out_valid();
    return (q.size() > 0) && (q[0].pos == DEPTH - 1);
  endfunction

  function automatic logic [DW-1:0] m_out_data();
    return q[0].d;
  endfunction

  // Advance one clock edge: model follows the handshake rules on the same edge.
  task automatic tick();
    logic acc;
    logic emit;
    int   lim;
    ent_t e;
    @(posedge clk);
    acc  = in_valid && m_in_ready();
    emit = m_out_valid() && out_ready;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (emit) void'(q.pop_front());
      for (int k = 0; k < q.size(); k++) begin
        lim = (k == 0) ? DEPTH - 1 : q[k-1].pos - 1;
        if (q[k].pos < lim) q[k].pos = q[k].pos + 1;
      end
      if (acc) begin
        e.d   = in_data;
        e.pos = 0;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({out_valid, occupancy, out_data} !== {1'b0, {OW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_pre_clock: got valid=%b occ=%0d data=%h, expected 0/0/0", out_valid, occupancy, out_data);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 16'hdead;
    tick();
    tick();
    n_tests++;
    if ({out_valid, occupancy, out_data} !== {1'b0, {OW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_held: got valid=%b occ=%0d data=%h, expected 0/0/0", out_valid, occupancy, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++;
    if ({in_ready, out_valid, occupancy} !== {1'b1, 1'b0, {OW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b valid=%b occ=%0d, expected 1/0/0", in_ready, out_valid, occupancy);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] words [3];
    logic          exp_v;
    words[0] = 16'h0102;
    words[1] = 16'h0304;
    words[2] = 16'h0506;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 3);
      in_data  = (c < 3) ? words[c] : 16'h0000;
      @(negedge clk);
      exp_v = (c >= 3) && (c <= 5);
      n_tests++;
      if (out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL stream_valid cycle %0d: got %b expected %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (out_data !== words[c-3]) begin
          n_fail++;
          $display("FAIL stream_data cycle %0d: got %h expected %h", c, out_data, words[c-3]);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] abc [3];
    abc[0] = 16'haaa1;
    abc[1] = 16'hbbb2;
    abc[2] = 16'hccc3;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = abc[c];
      tick();
    end
    in_data = 16'hdddd;
    @(negedge clk);
    n_tests++;
    if ({occupancy, in_ready, out_valid, out_data} !== {2'd3, 1'b0, 1'b1, abc[0]}) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d rdy=%b valid=%b data=%h, expected 3/0/1/%h", occupancy, in_ready, out_valid, out_data, abc[0]);
    end
    tick();
    n_tests++;
    if ({occupancy, out_data} !== {2'd3, abc[0]}) begin
      n_fail++;
      $display("FAIL bp_hold: got occ=%0d data=%h, expected 3/%h", occupancy, out_data, abc[0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({out_valid, out_data, in_ready} !== {1'b1, abc[c], 1'b1}) begin
        n_fail++;
        $display("FAIL bp_drain %0d: got valid=%b data=%h rdy=%b, expected 1/%h/1", c, out_valid, out_data, in_ready, abc[c]);
      end
      tick();
    end
    n_tests++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL bp_empty: got valid=%b occ=%0d, expected 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_bubble_collapse();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1a1a;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 16'h2b2b;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if ({occupancy, out_valid, out_data, in_ready} !== {2'd2, 1'b1, 16'h1a1a, 1'b1}) begin
      n_fail++;
      $display("FAIL bubble_state: got occ=%0d valid=%b data=%h rdy=%b, expected 2/1/1a1a/1", occupancy, out_valid, out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if ({out_valid, out_data, occupancy} !== {1'b1, 16'h2b2b, 2'd1}) begin
      n_fail++;
      $display("FAIL bubble_second: got valid=%b data=%h occ=%0d, expected 1/2b2b/1", out_valid, out_data, occupancy);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0f01;
    tick();
    in_data = 16'h0f02;
    tick();
    in_data = 16'h0f03;
    flush   = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({occupancy, in_ready} !== {2'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_cycle: got occ=%0d rdy=%b, expected 2/0", occupancy, in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({occupancy, out_valid} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_after: got occ=%0d valid=%b, expected 0/0", occupancy, out_valid);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    n_tests++;
    if ({occupancy, out_valid} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_not_accepted: got occ=%0d valid=%b, expected 0/0", occupancy, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (occupancy !== 2'd3) begin
      n_fail++;
      $display("FAIL areset_fill: got occ=%0d expected 3", occupancy);
    end
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    n_tests++;
    if ({out_valid, occupancy, out_data, in_ready} !== {1'b0, 2'd0, 16'h0000, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%b occ=%0d data=%h rdy=%b, expected 0/0/0000/1", out_valid, occupancy, out_data, in_ready);
    end
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 2);
      in_data  = DW'($urandom);
      @(negedge clk);
      n_tests++;
      if ({in_ready, out_valid, occupancy} !== {m_in_ready(), m_out_valid(), OW'(q.size())}) begin
        n_fail++;
        $display("FAIL areset_resume cycle %0d: got rdy=%b valid=%b occ=%0d, expected %b/%b/%0d", c, in_ready, out_valid, occupancy, m_in_ready(), m_out_valid(), q.size());
      end
      if (m_out_valid()) begin
        n_tests++;
        if (out_data !== m_out_data()) begin
          n_fail++;
          $display("FAIL areset_resume_data cycle %0d: got %h expected %h", c, out_data, m_out_data());
        end
      end
      tick();
    end
  endtask

  task automatic test_full_passthrough();
    int acc_cnt = 0;
    int emit_cnt = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = DW'($urandom);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = DW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) emit_cnt++;
      n_tests++;
      if ({occupancy, in_ready, out_valid} !== {2'd3, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL pass_state cycle %0d: got occ=%0d rdy=%b valid=%b, expected 3/1/1", c, occupancy, in_ready, out_valid);
      end
      n_tests++;
      if (out_data !== m_out_data()) begin
        n_fail++;
        $display("FAIL pass_data cycle %0d: got %h expected %h", c, out_data, m_out_data());
      end
      tick();
    end
    n_tests++;
    if ((acc_cnt != 10) || (emit_cnt != 10)) begin
      n_fail++;
      $display("FAIL pass_counts: got %0d accepts %0d emits, expected 10/10", acc_cnt, emit_cnt);
    end
    n_tests++;
    if (occupancy !== 2'd3) begin
      n_fail++;
      $display("FAIL pass_final_occ: got %0d expected 3", occupancy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      n_tests++;
      if ({in_ready, out_valid, occupancy} !== {m_in_ready(), m_out_valid(), OW'(q.size())}) begin
        n_fail++;
        $display("FAIL rand_ctrl cycle %0d: got rdy=%b valid=%b occ=%0d, expected %b/%b/%0d", c, in_ready, out_valid, occupancy, m_in_ready(), m_out_valid(), q.size());
      end
      if (m_out_valid()) begin
        n_tests++;
        if (out_data !== m_out_data()) begin
          n_fail++;
          $display("FAIL rand_data cycle %0d: got %h expected %h", c, out_data, m_out_data());
        end
      end
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_async_reset();
    test_full_passthrough();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg_array.md
PIPE_REG_ARRAY -- requirements
Module: pipe_reg_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of one channel.
REQ-002 The block SHALL have parameter CHANNELS, default 2, meaning the number of lanes moved together under one handshake.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages, legal range 1..16.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit, synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit, upstream offers in_data.
REQ-008 The block SHALL have port in_ready, output, 1 bit, block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data, input, CHANNELS*WIDTH bits, with lane k at bits [k*WIDTH +: WIDTH].
REQ-010 The block SHALL have port out_valid, output, 1 bit, last stage holds an entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit, downstream accepts out_data.
REQ-012 The block SHALL have port out_data, output, CHANNELS*WIDTH bits, last-stage data with the same lane packing.
REQ-013 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits, the count of valid stages.

Function
REQ-014 Stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and a data register d[i]; stage 0 is fed from the input and stage DEPTH-1 drives the outputs.
REQ-015 Stage i SHALL be ready when !v[i] or the stage downstream of it is ready; for the last stage, downstream ready is out_ready.
REQ-016 in_ready SHALL equal stage-0 ready AND !flush.
REQ-017 A stage that is ready SHALL load v and d from its upstream stage (or from in_valid/in_data for stage 0); a stage that is not ready SHALL hold.
REQ-018 Transfer SHALL occur only when valid and ready are both high on the same edge, at the input and at the output independently.
REQ-019 Latency through an empty pipe with out_ready high SHALL be exactly DEPTH cycles, and throughput SHALL be one entry per cycle.
REQ-020 Bubbles SHALL collapse: an invalid stage accepts new data even when downstream is stalled.
REQ-021 Entries SHALL leave in acceptance order and SHALL NOT be duplicated or dropped; all lanes of one entry move together.
REQ-022 out_data SHALL be d[DEPTH-1] whenever out_valid is high; its value when out_valid is low SHALL be the last loaded value (don't-care to consumers).
REQ-023 With all stages valid and out_ready low, in_ready SHALL be 0 and the full pipe SHALL hold steady.
REQ-024 With a full pipe and out_ready high, one entry SHALL be accepted and one emitted on the same edge, with occupancy unchanged.
REQ-025 occupancy SHALL equal the population count of v[] and SHALL be registered-consistent, i.e. it reflects the v[] state after each edge.
REQ-026 On an edge with flush high, all v[] SHALL clear, d[] SHALL be left unchanged, no input SHALL be accepted, and an output handshake in that cycle SHALL still count as consumed.
REQ-027 in_valid with in_ready low SHALL have no effect; upstream holds its data.

Reset
REQ-028 While rst is high, all v[] and d[] SHALL be 0, giving out_valid=0, out_data=0 and occupancy=0, independent of clk.
REQ-029 in_ready SHALL be 1 during and after reset while flush is low.
REQ-030 Asserting rst mid-transfer SHALL discard all entries immediately; the first edge after rst deasserts SHALL behave as an empty pipe.

Structure
REQ-031 A shared package pipe_pkg SHALL hold the default WIDTH, CHANNELS and DEPTH constants and the DEPTH legal-range limits.
REQ-032 One sub-module, pipe_stage (a single valid/data register with its ready equation), SHALL be instantiated DEPTH times via generate.
REQ-033 Elaboration SHALL fail for DEPTH outside 1..16 or for WIDTH<1 or CHANNELS<1.

Verification
REQ-034 Streaming: WIDTH=8, CHANNELS=2, DEPTH=3, in_data=16'h0102,16'h0304,16'h0506 on consecutive cycles with out_ready=1 -> the same words appear in order on out_valid starting 3 cycles after the first accept, with no gaps.
REQ-035 Backpressure: with DEPTH=3, fill with A,B,C while out_ready=0 -> occupancy=3 and in_ready=0; then raise out_ready -> A,B,C emerge in order and in_ready returns to 1 in the same cycle A is taken.
REQ-036 Bubble collapse: accept A, idle one cycle, accept B with out_ready=0 -> occupancy reaches 2 and A, B end in stages 2 and 1.
REQ-037 Flush: with occupancy=2 and in_valid=1, pulse flush for one cycle -> next cycle occupancy=0, out_valid=0, and the offered entry is not accepted.
REQ-038 Async reset: assert rst between clock edges while occupancy=3 -> out_valid and occupancy go to 0 before the next edge; resume streaming cleanly after release.
REQ-039 Full pass-through: full pipe with in_valid=1 and out_ready=1 for 10 cycles -> 10 accepts and 10 emits, and occupancy stays 3 throughout.
